// File: rtl/fbuff_arbiter.sv
// rtl/fbuff_arbiter.sv - single-port frame buffer arbiter, read priority, fixed-latency read return
// Optional writer starvation guard: FBUFF_WR_STARVE_GUARD_EN
module fbuff_arbiter #(
    parameter int FBUFF_WIDTH = 60,
    parameter int FBUFF_DEPTH = 3840,
    parameter int RD_LATENCY  = 1,
    parameter int MAX_WR_WAIT = 8,
    localparam int ADDR_W     = $clog2(FBUFF_DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   rd_req_i,
    input  logic [ADDR_W-1:0]      rd_addr_i,
    output logic                   rd_gnt_o,
    output logic [FBUFF_WIDTH-1:0] rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   wr_req_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [FBUFF_WIDTH-1:0] wr_data_i,
    output logic                   wr_gnt_o,
    output logic [ADDR_W-1:0]      fbuff_addr_o,
    output logic [FBUFF_WIDTH-1:0] fbuff_din_o,
    output logic                   fbuff_en_o,
    output logic                   fbuff_we_o,
    input  logic [FBUFF_WIDTH-1:0] fbuff_dout_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [FBUFF_WIDTH-1:0] din_q, din_d;
    logic [RD_LATENCY:0]    vld_q, vld_d;
    logic [FBUFF_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   force_wr;
    logic                   rd_acc;
    logic                   wr_acc;

`ifdef FBUFF_WR_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WR_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WR_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign force_wr = (wait_cnt_q == CNT_MAX);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!wr_req_i || wr_acc) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    assign rd_gnt_o = rd_req_i & ~force_wr;
    assign wr_gnt_o = wr_req_i & (force_wr | ~rd_req_i);
    assign rd_acc   = rd_req_i & rd_gnt_o;
    assign wr_acc   = wr_req_i & wr_gnt_o;

    always_comb begin
        state_d    = ST_IDLE;
        addr_d     = addr_q;
        din_d      = din_q;
        if (rd_acc) begin
            state_d = ST_RD;
            addr_d  = rd_addr_i;
        end else if (wr_acc) begin
            state_d = ST_WR;
            addr_d  = wr_addr_i;
            din_d   = wr_data_i;
        end
        // bit k set means a read accepted k edges ago; the top bit marks the capture edge
        vld_d      = {vld_q[RD_LATENCY-1:0], rd_acc};
        rd_valid_d = vld_q[RD_LATENCY];
        rd_data_d  = vld_q[RD_LATENCY] ? fbuff_dout_i : rd_data_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            din_q      <= '0;
            vld_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            vld_q      <= vld_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign fbuff_en_o   = (state_q != ST_IDLE);
    assign fbuff_we_o   = (state_q == ST_WR);
    assign fbuff_addr_o = addr_q;
    assign fbuff_din_o  = din_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign busy_o       = |vld_q;

endmodule
